sram_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port external SRAM controller between two requesters.
- Port 0 is the high-priority video scanout/line-fetch client. Port 1 is the low-priority framebuffer write / host client.
- Sequences exactly one SRAM operation at a time through the controller's mem/rw/ready handshake and returns read data with a one-cycle ack pulse.
- A burst limit on port 0 guarantees port 1 forward progress.

---
 rtl/sram_arbiter_if.sv | 50 +++++
 rtl/sram_arbiter.sv | 143 ++++++++++++++
 tb/tb_sram_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the two SRAM requesters, the arbiter and the SRAM controller.
// Ports: p0_*/p1_* requester handshakes, sram_* controller handshake, busy/grant status.
interface sram_arbiter_if #(
    parameter int AW = 20,
    parameter int DW = 8
);
    logic          p0_req;
    logic          p0_rw;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_ack;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_rw;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_ack;
    logic [DW-1:0] p1_rdata;

    logic          sram_mem;
    logic          sram_rw;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          sram_ready;
    logic [DW-1:0] sram_rdata;

    logic          busy;
    logic          grant;

    modport slave (
        input  p0_req, p0_rw, p0_addr, p0_wdata,
        output p0_ack, p0_rdata,
        input  p1_req, p1_rw, p1_addr, p1_wdata,
        output p1_ack, p1_rdata,
        output sram_mem, sram_rw, sram_addr, sram_wdata,
        input  sram_ready, sram_rdata,
        output busy, grant
    );

    modport master (
        output p0_req, p0_rw, p0_addr, p0_wdata,
        input  p0_ack, p0_rdata,
        output p1_req, p1_rw, p1_addr, p1_wdata,
        input  p1_ack, p1_rdata,
        input  sram_mem, sram_rw, sram_addr, sram_wdata,
        output sram_ready, sram_rdata,
        input  busy, grant
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one SRAM controller: port 0 (video) has priority,
// port 1 (host/framebuffer) is protected by a port 0 burst limit.
// Ports: clk, rst (sync, active-high), bus (sram_arbiter_if.slave: requester
// handshakes p0_*/p1_*, controller handshake sram_*, status busy/grant).
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration instead of
// fixed priority with burst limit.
module sram_arbiter #(
    parameter int AW           = 20,
    parameter int DW           = 8,
    parameter int MAX_P0_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        A_IDLE  = 2'b00,
        A_ISSUE = 2'b01,
        A_WAIT  = 2'b10
    } state_t;

    state_t        state;
    logic          any_req;
    logic          win;
    logic          sel_rw;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign any_req = bus.p0_req | bus.p1_req;
    assign bus.busy = (state != A_IDLE);

`ifdef SRAM_ARB_RR_EN
    // Port that won the last arbitration; resets to 1 so port 0 goes first.
    logic last;

    always_comb begin
        win = 1'b0;
        if (bus.p0_req && bus.p1_req)
            win = ~last;
        else if (bus.p1_req)
            win = 1'b1;
    end
`else
    logic [3:0] burst;
    logic       at_limit;

    assign at_limit = (burst >= 4'(MAX_P0_BURST));

    always_comb begin
        win = 1'b0;
        if (bus.p0_req && bus.p1_req)
            win = at_limit;
        else if (bus.p1_req)
            win = 1'b1;
    end
`endif

    always_comb begin
        sel_rw    = win ? bus.p1_rw    : bus.p0_rw;
        sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
        sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= A_IDLE;
            bus.sram_mem   <= 1'b0;
            bus.sram_rw    <= 1'b1;
            bus.sram_addr  <= '0;
            bus.sram_wdata <= '0;
            bus.p0_ack     <= 1'b0;
            bus.p1_ack     <= 1'b0;
            bus.p0_rdata   <= '0;
            bus.p1_rdata   <= '0;
            bus.grant      <= 1'b0;
`ifdef SRAM_ARB_RR_EN
            last           <= 1'b1;
`else
            burst          <= '0;
`endif
        end else begin
            bus.p0_ack <= 1'b0;
            bus.p1_ack <= 1'b0;
            case (state)
                A_IDLE: begin
                    if (any_req) begin
                        bus.grant      <= win;
                        bus.sram_rw    <= sel_rw;
                        bus.sram_addr  <= sel_addr;
                        bus.sram_wdata <= sel_wdata;
                        bus.sram_mem   <= 1'b1;
                        state          <= A_ISSUE;
                    end
`ifdef SRAM_ARB_RR_EN
                    if (any_req)
                        last <= win;
`else
                    // Count only port 0 wins taken while port 1 waits.
                    if (!bus.p1_req || win)
                        burst <= '0;
                    else
                        burst <= burst + 4'd1;
`endif
                end
                A_ISSUE: begin
                    if (bus.sram_ready) begin
                        bus.sram_mem <= 1'b0;
                        state        <= A_WAIT;
                    end
                end
                A_WAIT: begin
                    if (bus.sram_ready) begin
                        state <= A_IDLE;
                        if (bus.grant) begin
                            bus.p1_ack <= 1'b1;
                            if (bus.sram_rw)
                                bus.p1_rdata <= bus.sram_rdata;
                        end else begin
                            bus.p0_ack <= 1'b1;
                            if (bus.sram_rw)
                                bus.p0_rdata <= bus.sram_rdata;
                        end
                    end
                end
                default: begin
                    state          <= A_IDLE;
                    bus.sram_mem   <= 1'b0;
                    bus.sram_rw    <= 1'b1;
                    bus.sram_addr  <= '0;
                    bus.sram_wdata <= '0;
                    bus.p0_rdata   <= '0;
                    bus.p1_rdata   <= '0;
                    bus.grant      <= 1'b0;
`ifdef SRAM_ARB_RR_EN
                    last           <= 1'b1;
`else
                    burst          <= '0;
`endif
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural 3-cycle SRAM controller.
// Ports: none (top-level bench).
module tb_sram_arbiter;
    localparam int AW   = 20;
    localparam int DW   = 8;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #10 clk = ~clk;

    sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    sram_arbiter #(
        .AW(AW),
        .DW(DW),
        .MAX_P0_BURST(MAXB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Controller model: accepts in the mem cycle, ready low two cycles,
    // ready high with data in the fourth cycle of the op.
    logic [7:0] sram_arr [int];
    logic [7:0] ref_mem  [int];
    int         ctl_c;

    assign bus.sram_ready = (ctl_c == 0) || (ctl_c == 3);

    always @(posedge clk) begin
        if (rst) begin
            ctl_c          <= 0;
            bus.sram_rdata <= 8'h00;
        end else if (ctl_c == 0) begin
            if (bus.sram_mem) begin
                ctl_c <= 1;
                if (bus.sram_rw)
                    bus.sram_rdata <= sram_arr.exists(int'(bus.sram_addr)) ?
                                      sram_arr[int'(bus.sram_addr)] : 8'h00;
                else
                    sram_arr[int'(bus.sram_addr)] = bus.sram_wdata;
            end
        end else if (ctl_c == 3) begin
            ctl_c <= 0;
        end else begin
            ctl_c <= ctl_c + 1;
        end
    end

    int ack0 = 0;
    int ack1 = 0;
    always @(negedge clk) begin
        if (bus.p0_ack === 1'b1) ack0++;
        if (bus.p1_ack === 1'b1) ack1++;
    end

    logic [7:0] last_rd [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    task automatic preload(input logic [19:0] a, input logic [7:0] d);
        sram_arr[int'(a)] = d;
        ref_mem[int'(a)]  = d;
    endtask

    task automatic drive(input int port, input logic req, input logic rw,
                         input logic [19:0] a, input logic [7:0] wd);
        if (port == 0) begin
            bus.p0_req = req; bus.p0_rw = rw; bus.p0_addr = a; bus.p0_wdata = wd;
        end else begin
            bus.p1_req = req; bus.p1_rw = rw; bus.p1_addr = a; bus.p1_wdata = wd;
        end
    endtask

    // One isolated operation: issue in cycle 1, ack + rdata in cycle 5.
    task automatic single_op(input int port, input logic rw,
                             input logic [19:0] a, input logic [7:0] wd);
        int         lat;
        logic       seen;
        logic [7:0] exp_rd;
        drive(port, 1'b1, rw, a, wd);
        tick();
        chk("issue_mem", 32'(bus.sram_mem), 32'd1);
        chk("issue_addr", 32'(bus.sram_addr), 32'(a));
        chk("issue_rw", 32'(bus.sram_rw), 32'(rw));
        chk("issue_grant", 32'(bus.grant), 32'(port));
        if (!rw) chk("issue_wdata", 32'(bus.sram_wdata), 32'(wd));
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            tick();
            lat++;
            seen = (port == 0) ? bus.p0_ack : bus.p1_ack;
        end
        chk("ack_latency", 32'(lat), 32'd5);
        chk("other_ack", 32'((port == 0) ? bus.p1_ack : bus.p0_ack), 32'd0);
        exp_rd = rw ? ref_rd(a) : last_rd[port];
        chk("rdata", 32'((port == 0) ? bus.p0_rdata : bus.p1_rdata), 32'(exp_rd));
        if (rw) last_rd[port] = exp_rd;
        else    ref_mem[int'(a)] = wd;
        drive(port, 1'b0, rw, a, wd);
        tick();
        chk("ack_pulse", 32'((port == 0) ? bus.p0_ack : bus.p1_ack), 32'd0);
        chk("rdata_hold", 32'((port == 0) ? bus.p0_rdata : bus.p1_rdata), 32'(last_rd[port]));
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin : main
        int         n, cyc, last_cyc, b0, lat;
        logic       seen, got, exp_g;
        logic [19:0] a1, a2;

        rst = 1'b1;
        drive(0, 1'b0, 1'b1, 20'h0, 8'h0);
        drive(1, 1'b0, 1'b1, 20'h0, 8'h0);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem", 32'(bus.sram_mem), 32'd0);
        chk("rst_rw", 32'(bus.sram_rw), 32'd1);
        chk("rst_addr", 32'(bus.sram_addr), 32'd0);
        chk("rst_wdata", 32'(bus.sram_wdata), 32'd0);
        chk("rst_ack", 32'({bus.p0_ack, bus.p1_ack}), 32'd0);
        chk("rst_rdata", 32'({bus.p0_rdata, bus.p1_rdata}), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);

        // Port 0 read, then port 1 write with read-back through port 0.
        preload(20'h12345, 8'hA5);
        single_op(0, 1'b1, 20'h12345, 8'h00);
        single_op(1, 1'b0, 20'h00010, 8'h3C);
        single_op(0, 1'b1, 20'h00010, 8'h00);

        // Randomised isolated operations against the reference memory.
        for (int i = 0; i < 16; i++) begin
            single_op(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      20'h00100 + 20'($urandom_range(0, 7)), 8'($urandom));
        end

        // Contention: both ports request continuously with fresh addresses.
        drive(0, 1'b1, 1'b1, 20'h00100 + 20'($urandom_range(0, 7)), 8'h00);
        drive(1, 1'b1, 1'b0, 20'h80000, 8'($urandom));
        n        = 0;
        cyc      = 0;
        last_cyc = 0;
        while (n < 10 && cyc < 100) begin
            tick();
            cyc++;
            if (bus.p0_ack || bus.p1_ack) begin
                got = bus.p1_ack;
`ifdef SRAM_ARB_RR_EN
                exp_g = (n % 2) == 1;
`else
                exp_g = (n % (MAXB + 1)) == MAXB;
`endif
                chk("cont_grant", 32'(got), 32'(exp_g));
                if (n > 0) chk("cont_gap", 32'(cyc - last_cyc), 32'd5);
                if (!got) chk("cont_rdata", 32'(bus.p0_rdata), 32'(ref_rd(bus.p0_addr)));
                else      ref_mem[int'(bus.p1_addr)] = bus.p1_wdata;
                last_cyc = cyc;
                n++;
                if (n == 10) begin
                    bus.p0_req = 1'b0;
                    bus.p1_req = 1'b0;
                end else if (!got) begin
                    bus.p0_addr = 20'h00100 + 20'($urandom_range(0, 7));
                end else begin
                    bus.p1_addr  = 20'h80000 + 20'(n);
                    bus.p1_wdata = 8'($urandom);
                end
            end
        end
        chk("cont_count", 32'(n), 32'd10);
        last_rd[0] = bus.p0_rdata === 8'hxx ? 8'h00 : last_rd[0];
        tick();
        chk("cont_idle", 32'(bus.busy), 32'd0);

        // Reset in the wait phase of a port 0 read abandons it silently.
        drive(0, 1'b1, 1'b1, 20'h12345, 8'h00);
        tick();
        tick();
        chk("mid_busy", 32'(bus.busy), 32'd1);
        chk("mid_mem", 32'(bus.sram_mem), 32'd0);
        b0  = ack0;
        rst = 1'b1;
        bus.p0_req = 1'b0;
        tick();
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_mem", 32'(bus.sram_mem), 32'd0);
        chk("rstmid_ack", 32'(bus.p0_ack), 32'd0);
        chk("rstmid_rdata", 32'(bus.p0_rdata), 32'd0);
        rst = 1'b0;
        repeat (6) tick();
        chk("rstmid_noack", 32'(ack0), 32'(b0));
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        single_op(0, 1'b1, 20'h00010, 8'h00);

        // Back-to-back: req held across ack, address changed in the ack cycle.
        a1 = 20'h00010;
        a2 = 20'h12345;
        b0 = ack0;
        drive(0, 1'b1, 1'b1, a1, 8'h00);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            tick();
            lat++;
            seen = bus.p0_ack;
        end
        chk("b2b_lat1", 32'(lat), 32'd5);
        chk("b2b_rd1", 32'(bus.p0_rdata), 32'(ref_rd(a1)));
        bus.p0_addr = a2;
        tick();
        chk("b2b_mem", 32'(bus.sram_mem), 32'd1);
        chk("b2b_addr", 32'(bus.sram_addr), 32'(a2));
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < 12) begin
            tick();
            lat++;
            seen = bus.p0_ack;
        end
        chk("b2b_lat2", 32'(lat), 32'd5);
        chk("b2b_rd2", 32'(bus.p0_rdata), 32'(ref_rd(a2)));
        bus.p0_req = 1'b0;
        tick();
        tick();
        chk("b2b_acks", 32'(ack0 - b0), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
